tm1638_frame_sched: RTL and testbench
=====================================

// Module: tm1638_frame_sched
// PURPOSE
//  Frame scheduler and arbiter in front of the TM1638 serial display engine.
//  Shares the engine between two frame requesters (3 display bytes each) with round-robin grant.
//  Issues a periodic refresh of the last shown frame when no request is pending.
//  Supplies the brightness command byte and guards each transaction with a watchdog.
// PARAMETERS
//  REFRESH_DIV  24'd1_000_000  idle cycles between automatic refreshes (min 2)
//  TIMEOUT_CYC  24'd8_000_000  max cycles in WAIT before drv_done_i (min 2)
// PORTS
//  clk          in   1   system clock; single clock domain
//  rst_n        in   1   reset, asynchronous assert, active-low
//  req_i        in   2   frame request per requester; held high until own ack_o
//  req_data_i   in   48  payload; [23:0] requester 0, [47:24] requester 1; {data3,data2,data1}
//  brightness_i in   3   display brightness, sampled at grant
//  drv_busy_i   in   1   engine busy (mid-transaction)
//  drv_done_i   in   1   engine one-cycle completion pulse
//  drv_start_o  out  1   one-cycle transaction start pulse to engine
//  drv_data_o   out  24  frame bytes to engine {data3,data2,data1}
//  drv_cmd3_o   out  8   display-control command {5'b10001, brightness}
//  ack_o        out  2   one-cycle completion pulse to granted requester
//  busy_o       out  1   high in any state other than IDLE
//  timeout_o    out  1   sticky watchdog flag
//  frame_cnt_o  out  16  completed transactions, requests and refreshes
// BEHAVIOUR
//  Reset (rst_n=0, async): state=IDLE; drv_start_o=0, drv_data_o=0, drv_cmd3_o=8'h88.
//   Also ack_o=0, busy_o=0, timeout_o=0, frame_cnt_o=0.
//   Shadow frame=0, refresh counter=0, RR pointer favours requester 0.
//   Reset mid-transaction aborts without ack; engine is not notified.
//  States: IDLE -> ISSUE -> WAIT -> ACK -> IDLE; WAIT -> IDLE on timeout.
//  IDLE: req_i sampled only here. Arbitration per cycle:
//   - exactly one req -> grant it;
//   - both -> grant the one not granted last; pointer updates on each grant;
//   - none and refresh counter == REFRESH_DIV-1 -> refresh grant of the shadow frame.
//   - Requests beat refresh in the same cycle.
//   On grant: register drv_data_o and shadow (request payload only).
//    Register drv_cmd3_o from brightness_i. Go to ISSUE next cycle.
//  Refresh counter: increments in IDLE only, saturates at REFRESH_DIV-1.
//   Clears on every transition to ISSUE.
//  ISSUE: drv_start_o=1 for exactly the first cycle with drv_busy_i=0, then go to WAIT.
//   Stays in ISSUE while drv_busy_i=1.
//  Latency: req_i high in IDLE at cycle t -> drv_start_o at t+1 if engine is free.
//  WAIT: drv_data_o/drv_cmd3_o held stable. Watchdog counts from 0.
//   drv_done_i=1 -> ACK.
//   Watchdog == TIMEOUT_CYC-1 without done -> timeout_o<=1, go IDLE, no ack.
//    The request stays pending and is re-arbitrated.
//   Done and timeout in the same cycle -> done wins.
//  ACK: one cycle. ack_o[g]=1 for a request grant; ack_o stays 0 for a refresh.
//   frame_cnt_o += 1, wrapping 16'hFFFF -> 0. Then IDLE.
//  drv_done_i outside WAIT is ignored. timeout_o clears only on reset.
//  Requester that drops req_i before ack: transaction still completes; ack pulse still issued.
// TESTING
//  1 Reset, req_i=01, data0=24'h76_79_3F, engine idle
//    -> start at t+1, drv_data_o=24'h76793F; done -> ack_o=01 next cycle; frame_cnt=1.
//  2 req_i=11 held three rounds -> grants 0,1,0; ack_o alternates 01,10,01; no refresh between.
//  3 No requests, REFRESH_DIV=16 -> start pulse every 16 idle cycles plus transaction time.
//    drv_data_o = last request frame; ack_o stays 00.
//  4 drv_busy_i=1 for 5 cycles in ISSUE -> drv_start_o stays 0, then one pulse when busy drops.
//  5 TIMEOUT_CYC=32, never pulse done -> timeout_o=1 after 32 WAIT cycles, no ack.
//    Held req re-issued; done then -> ack.
//  6 rst_n low mid-WAIT -> all outputs 0 immediately except drv_cmd3_o=8'h88.
//    brightness_i=3'd5 on next grant -> drv_cmd3_o=8'h8D.

Source files
------------

// File: rtl/tm1638_frame_sched.sv
// Frame scheduler for the TM1638 display engine: round-robin between two
// frame requesters, periodic refresh of the last shown frame, per-transaction watchdog.
//
// state | meaning
// IDLE  | arbitrate requests, count towards the next refresh
// ISSUE | granted frame registered, waiting for the engine to be free to start
// WAIT  | engine running, watchdog counting down
// ACK   | completion: ack to the requester (none for refresh), bump frame count
module tm1638_frame_sched #(
    parameter logic [23:0] REFRESH_DIV = 24'd1_000_000,
    parameter logic [23:0] TIMEOUT_CYC = 24'd8_000_000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  req_i,
    input  logic [47:0] req_data_i,
    input  logic [2:0]  brightness_i,
    input  logic        drv_busy_i,
    input  logic        drv_done_i,
    output logic        drv_start_o,
    output logic [23:0] drv_data_o,
    output logic [7:0]  drv_cmd3_o,
    output logic [1:0]  ack_o,
    output logic        busy_o,
    output logic        timeout_o,
    output logic [15:0] frame_cnt_o
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_ACK   = 2'd3
    } state_t;

    state_t      state;
    logic [23:0] shadow;
    logic [23:0] refresh_cnt;
    logic [23:0] wdog_cnt;
    logic        rr_last;
    logic        grant_idx;
    logic        grant_refresh;
    logic        req_sel;
    logic [23:0] req_frame;

    // With both requesting, the one not served last wins.
    assign req_sel   = (req_i == 2'b11) ? ~rr_last : req_i[1];
    assign req_frame = req_sel ? req_data_i[47:24] : req_data_i[23:0];

    // Start is decoded so the pulse lands in the first free ISSUE cycle.
    assign drv_start_o = (state == S_ISSUE) && !drv_busy_i;
    assign busy_o      = (state != S_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= S_IDLE;
            drv_data_o    <= 24'd0;
            drv_cmd3_o    <= 8'h88;
            ack_o         <= 2'b00;
            timeout_o     <= 1'b0;
            frame_cnt_o   <= 16'd0;
            shadow        <= 24'd0;
            refresh_cnt   <= 24'd0;
            wdog_cnt      <= 24'd0;
            rr_last       <= 1'b1;
            grant_idx     <= 1'b0;
            grant_refresh <= 1'b0;
        end else begin
            ack_o <= 2'b00;
            case (state)
                S_IDLE: begin
                    if (req_i != 2'b00) begin
                        grant_idx     <= req_sel;
                        grant_refresh <= 1'b0;
                        rr_last       <= req_sel;
                        drv_data_o    <= req_frame;
                        shadow        <= req_frame;
                        drv_cmd3_o    <= {5'b10001, brightness_i};
                        refresh_cnt   <= 24'd0;
                        state         <= S_ISSUE;
                    end else if (refresh_cnt == REFRESH_DIV - 24'd1) begin
                        grant_refresh <= 1'b1;
                        drv_data_o    <= shadow;
                        drv_cmd3_o    <= {5'b10001, brightness_i};
                        refresh_cnt   <= 24'd0;
                        state         <= S_ISSUE;
                    end else begin
                        refresh_cnt <= refresh_cnt + 24'd1;
                    end
                end
                S_ISSUE: begin
                    if (!drv_busy_i) begin
                        wdog_cnt <= TIMEOUT_CYC - 24'd1;
                        state    <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (drv_done_i) begin
                        if (!grant_refresh)
                            ack_o <= grant_idx ? 2'b10 : 2'b01;
                        frame_cnt_o <= frame_cnt_o + 16'd1;
                        state       <= S_ACK;
                    end else if (wdog_cnt == 24'd0) begin
                        // Abandon without ack; a held request is simply re-arbitrated.
                        timeout_o <= 1'b1;
                        state     <= S_IDLE;
                    end else begin
                        wdog_cnt <= wdog_cnt - 24'd1;
                    end
                end
                S_ACK: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tm1638_frame_sched.sv
// Scoreboard bench for tm1638_frame_sched: expected starts/acks are queued by the
// stimulus from a round-robin reference model and popped by an independent monitor.
module tb_tm1638_frame_sched;

    localparam logic [23:0] RDIV = 24'd16;
    localparam logic [23:0] TCYC = 24'd32;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  req_i;
    logic [47:0] req_data_i;
    logic [2:0]  brightness_i;
    logic        drv_busy_i;
    logic        drv_done_i;
    logic        drv_start_o;
    logic [23:0] drv_data_o;
    logic [7:0]  drv_cmd3_o;
    logic [1:0]  ack_o;
    logic        busy_o;
    logic        timeout_o;
    logic [15:0] frame_cnt_o;

    logic eng_busy, ext_busy, eng_hang, eng_fixed, eng_active;
    int   eng_lat;
    assign drv_busy_i = eng_busy | ext_busy;

    tm1638_frame_sched #(.REFRESH_DIV(RDIV), .TIMEOUT_CYC(TCYC)) dut (
        .clk(clk), .rst_n(rst_n), .req_i(req_i), .req_data_i(req_data_i),
        .brightness_i(brightness_i), .drv_busy_i(drv_busy_i), .drv_done_i(drv_done_i),
        .drv_start_o(drv_start_o), .drv_data_o(drv_data_o), .drv_cmd3_o(drv_cmd3_o),
        .ack_o(ack_o), .busy_o(busy_o), .timeout_o(timeout_o), .frame_cnt_o(frame_cnt_o)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int start_seen = 0, ack_seen = 0;
    int last_start_cyc = 0, last_ack_cyc = 0;

    logic [23:0] exp_data_q[$];
    logic [7:0]  exp_cmd_q[$];
    logic [1:0]  exp_ack_q[$];
    logic [15:0] exp_cnt_q[$];

    // reference model state
    logic        rr_last_m;
    logic [23:0] shadow_m;
    logic [15:0] cnt_m;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic pick(input logic [1:0] m, input logic last);
        if (m == 2'b11) return ~last;
        return m[1];
    endfunction

    task automatic push_start(input logic [23:0] d, input logic [2:0] b);
        exp_data_q.push_back(d);
        exp_cmd_q.push_back({5'b10001, b});
    endtask

    task automatic push_ack(input logic g);
        exp_ack_q.push_back(g ? 2'b10 : 2'b01);
        cnt_m = cnt_m + 16'd1;
        exp_cnt_q.push_back(cnt_m);
    endtask

    task automatic wait_acks(input int target, input string name);
        int n = 0;
        while (ack_seen < target && n < 3000) begin
            tick();
            n++;
        end
        total++;
        if (ack_seen < target) begin
            bad++;
            $display("FAIL %s: ack wait expired, acks=%0d needed=%0d", name, ack_seen, target);
        end
    endtask

    task automatic wait_starts(input int target, input string name);
        int n = 0;
        while (start_seen < target && n < 3000) begin
            tick();
            n++;
        end
        total++;
        if (start_seen < target) begin
            bad++;
            $display("FAIL %s: start wait expired, starts=%0d needed=%0d", name, start_seen, target);
        end
    endtask

    task automatic run_rounds(input logic [1:0] mask, input int n, input logic [2:0] b);
        logic [23:0] d0, d1;
        logic        g;
        int          target;
        d0 = 24'($urandom);
        d1 = 24'($urandom);
        for (int i = 0; i < n; i++) begin
            g = pick(mask, rr_last_m);
            rr_last_m = g;
            shadow_m  = g ? d1 : d0;
            push_start(shadow_m, b);
            push_ack(g);
        end
        target = ack_seen + n;
        tick();
        brightness_i = b;
        req_data_i   = {d1, d0};
        req_i        = mask;
        wait_acks(target, "rounds");
        req_i = 2'b00;
    endtask

    // Engine model: done pulse a programmable number of cycles after each start.
    initial begin
        int L;
        eng_busy = 1'b0;
        drv_done_i = 1'b0;
        eng_active = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n && drv_start_o && !eng_hang) begin
                L = eng_fixed ? eng_lat : int'($urandom_range(1, 6));
                eng_active = 1'b1;
                tick();
                eng_busy = 1'b1;
                repeat (L - 1) tick();
                drv_done_i = 1'b1;
                eng_busy = 1'b0;
                tick();
                drv_done_i = 1'b0;
                eng_active = 1'b0;
            end
        end
    end

    // Monitor: pops the scoreboard whenever the DUT presents a start or an ack.
    initial forever begin
        @(negedge clk);
        if (rst_n) begin
            if (drv_start_o) begin
                start_seen++;
                last_start_cyc = cyc;
                if (exp_data_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL start_unexpected: got data %h cmd %h expected none", drv_data_o, drv_cmd3_o);
                end else begin
                    check("start_data", 32'(drv_data_o), 32'(exp_data_q.pop_front()));
                    check("start_cmd3", 32'(drv_cmd3_o), 32'(exp_cmd_q.pop_front()));
                end
            end
            if (ack_o != 2'b00) begin
                ack_seen++;
                last_ack_cyc = cyc;
                if (exp_ack_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL ack_unexpected: got ack %b expected none", ack_o);
                end else begin
                    check("ack_value", 32'(ack_o), 32'(exp_ack_q.pop_front()));
                    check("frame_cnt", 32'(frame_cnt_o), 32'(exp_cnt_q.pop_front()));
                end
            end
        end
    end

    initial begin
        #500_000;
        $display("FAIL global_timeout: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "bench timeout");
    end

    initial begin
        logic [23:0] d;
        logic [2:0]  b;
        logic [1:0]  m;
        int base, t0, c1, c2, c3, s, n, target;

        rst_n = 1'b0;
        req_i = 2'b00;
        req_data_i = 48'd0;
        brightness_i = 3'd0;
        ext_busy = 1'b0;
        eng_hang = 1'b0;
        eng_fixed = 1'b1;
        eng_lat = 2;
        rr_last_m = 1'b1;
        shadow_m = 24'd0;
        cnt_m = 16'd0;

        // reset values
        #12;
        check("rst_start", 32'(drv_start_o), 32'd0);
        check("rst_data", 32'(drv_data_o), 32'd0);
        check("rst_cmd3", 32'(drv_cmd3_o), 32'h88);
        check("rst_ack", 32'(ack_o), 32'd0);
        check("rst_busy", 32'(busy_o), 32'd0);
        check("rst_timeout", 32'(timeout_o), 32'd0);
        check("rst_frame_cnt", 32'(frame_cnt_o), 32'd0);
        tick();
        rst_n = 1'b1;

        // single request, start latency and ack latency
        b = 3'($urandom_range(0, 7));
        push_start(24'h76793F, b);
        push_ack(1'b0);
        rr_last_m = 1'b0;
        shadow_m  = 24'h76793F;
        target = ack_seen + 1;
        tick();
        brightness_i = b;
        req_data_i = {24'($urandom), 24'h76793F};
        req_i = 2'b01;
        t0 = cyc;
        wait_acks(target, "t1_ack");
        req_i = 2'b00;
        check("t1_start_latency", 32'(last_start_cyc - t0), 32'd1);
        check("t1_ack_latency", 32'(last_ack_cyc - last_start_cyc), 32'd3);

        // contention held over several rounds, then random mixes
        eng_fixed = 1'b0;
        run_rounds(2'b11, 3, 3'($urandom_range(0, 7)));
        for (int p = 0; p < 6; p++) begin
            m = 2'($urandom_range(1, 3));
            n = (m == 2'b11) ? int'($urandom_range(2, 4)) : 1;
            run_rounds(m, n, 3'($urandom_range(0, 7)));
        end

        // idle refresh of the last frame
        b = 3'($urandom_range(0, 7));
        brightness_i = b;
        eng_fixed = 1'b1;
        eng_lat = 3;
        base = start_seen;
        for (int i = 0; i < 3; i++) begin
            push_start(shadow_m, b);
            cnt_m = cnt_m + 16'd1;
        end
        wait_starts(base + 1, "refresh1");
        c1 = last_start_cyc;
        wait_starts(base + 2, "refresh2");
        c2 = last_start_cyc;
        wait_starts(base + 3, "refresh3");
        c3 = last_start_cyc;
        check("refresh_first_gap", 32'(c1 - last_ack_cyc), 32'd17);
        check("refresh_period_a", 32'(c2 - c1), 32'd21);
        check("refresh_period_b", 32'(c3 - c2), 32'd21);
        n = 0;
        while (busy_o && n < 100) begin
            tick();
            n++;
        end
        check("refresh_frame_cnt", 32'(frame_cnt_o), 32'(cnt_m));

        // engine busy holds off the start pulse
        eng_fixed = 1'b0;
        d = 24'($urandom);
        b = 3'($urandom_range(0, 7));
        push_start(d, b);
        push_ack(1'b0);
        rr_last_m = 1'b0;
        shadow_m = d;
        target = ack_seen + 1;
        tick();
        ext_busy = 1'b1;
        brightness_i = b;
        req_data_i = {24'($urandom), d};
        req_i = 2'b01;
        tick();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("issue_hold_start", 32'(drv_start_o), 32'd0);
            check("issue_hold_busy", 32'(busy_o), 32'd1);
            tick();
        end
        ext_busy = 1'b0;
        @(negedge clk);
        check("issue_release_start", 32'(drv_start_o), 32'd1);
        wait_acks(target, "busy_ack");
        req_i = 2'b00;

        // watchdog timeout with the request held, then normal completion
        check("timeout_pre", 32'(timeout_o), 32'd0);
        d = 24'($urandom);
        b = 3'($urandom_range(0, 7));
        push_start(d, b);
        push_start(d, b);
        push_ack(1'b1);
        rr_last_m = 1'b1;
        shadow_m = d;
        eng_hang = 1'b1;
        target = ack_seen + 1;
        base = start_seen;
        tick();
        brightness_i = b;
        req_data_i = {d, 24'($urandom)};
        req_i = 2'b10;
        wait_starts(base + 1, "timeout_start");
        eng_hang = 1'b0;
        s = last_start_cyc;
        n = 0;
        while (!timeout_o && n < 200) begin
            tick();
            n++;
        end
        check("timeout_delay", 32'(cyc - s), 32'd33);
        wait_acks(target, "timeout_reissue_ack");
        req_i = 2'b00;
        check("timeout_sticky", 32'(timeout_o), 32'd1);

        // reset in the middle of WAIT
        eng_fixed = 1'b1;
        eng_lat = 20;
        d = 24'($urandom);
        b = 3'($urandom_range(0, 7));
        push_start(d, b);
        base = start_seen;
        tick();
        brightness_i = b;
        req_data_i = {24'($urandom), d};
        req_i = 2'b01;
        wait_starts(base + 1, "reset_start");
        repeat (3) tick();
        rst_n = 1'b0;
        #1;
        check("midrst_start", 32'(drv_start_o), 32'd0);
        check("midrst_data", 32'(drv_data_o), 32'd0);
        check("midrst_cmd3", 32'(drv_cmd3_o), 32'h88);
        check("midrst_ack", 32'(ack_o), 32'd0);
        check("midrst_busy", 32'(busy_o), 32'd0);
        check("midrst_timeout", 32'(timeout_o), 32'd0);
        check("midrst_frame_cnt", 32'(frame_cnt_o), 32'd0);
        req_i = 2'b00;
        rr_last_m = 1'b1;
        shadow_m = 24'd0;
        cnt_m = 16'd0;
        n = 0;
        while (eng_active && n < 100) begin
            tick();
            n++;
        end
        tick();
        rst_n = 1'b1;
        eng_fixed = 1'b0;
        run_rounds(2'b11, 2, 3'd5);

        tick();
        check("left_starts", 32'(exp_data_q.size()), 32'd0);
        check("left_acks", 32'(exp_ack_q.size()), 32'd0);
        repeat (3) tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
